// File: rtl/bnn_pkg.sv
// Shared constants and state type for the MNIST BNN datapath: stream lengths,
// loader counter widths and the loader FSM state encoding.
package bnn_pkg;

    localparam int PIX_BITS  = 784;
    localparam int W1_BITS   = 72;
    localparam int W2_BITS   = 288;
    localparam int W3_BITS   = 1960;
    localparam int WT        = W1_BITS + W2_BITS + W3_BITS;

    // Sized to also count the optional trailing parity bit.
    localparam int PIX_CNT_W = 10;
    localparam int W_CNT_W   = 12;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } loader_state_t;

endpackage

// File: rtl/bnn_stream_loader_if.sv
// Bundle between the serial source (master) and the stream loader (slave):
// control/data pins in, assembled vectors and status out.
interface bnn_stream_loader_if #(
    parameter int PIX_BITS = bnn_pkg::PIX_BITS,
    parameter int W1_BITS  = bnn_pkg::W1_BITS,
    parameter int W2_BITS  = bnn_pkg::W2_BITS,
    parameter int W3_BITS  = bnn_pkg::W3_BITS
);
    logic                start;
    logic                in_valid;
    logic                d_in_p;
    logic                d_in_w;
    logic [PIX_BITS-1:0] pixels;
    logic [W1_BITS-1:0]  weights1;
    logic [W2_BITS-1:0]  weights2;
    logic [W3_BITS-1:0]  weights3;
    logic                busy;
    logic                load_done;
    logic                parity_err;

    modport master (
        output start, in_valid, d_in_p, d_in_w,
        input  pixels, weights1, weights2, weights3, busy, load_done, parity_err
    );

    modport slave (
        input  start, in_valid, d_in_p, d_in_w,
        output pixels, weights1, weights2, weights3, busy, load_done, parity_err
    );

endinterface

// File: rtl/bit_stream_shifter.sv
// One serial stream: right-shifting capture register, saturating bit counter,
// completion flags and (when PARITY_EN) a checked trailing even-parity bit.
module bit_stream_shifter #(
    parameter int LEN       = 8,
    parameter int CNT_W     = 4,
    parameter bit PARITY_EN = 1'b0
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           clear_i,
    input  logic           shift_i,
    input  logic           d_i,
    output logic [LEN-1:0] data_o,
    output logic           last_o,
    output logic           complete_o,
    output logic           parity_err_o
);
    localparam int LIMIT = PARITY_EN ? LEN + 1 : LEN;

    logic [LEN-1:0]   data_q;
    logic [CNT_W-1:0] cnt_q;
    logic             accept;
    logic             data_phase;

    // Saturation is by comparison; bits beyond the limit are simply dropped.
    assign accept     = shift_i && (cnt_q < CNT_W'(LIMIT));
    assign data_phase = cnt_q < CNT_W'(LEN);

    // NOTE: the capture register is reset as well, because zeroed vectors after
    // reset are a visible output state, not just an initial value.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_q <= '0;
            cnt_q  <= '0;
        end else if (clear_i) begin
            cnt_q  <= '0;
        end else if (accept) begin
            cnt_q <= cnt_q + 1'b1;
            if (data_phase) data_q <= {d_i, data_q[LEN-1:1]};
        end
    end

    assign data_o     = data_q;
    assign last_o     = accept && (cnt_q == CNT_W'(LIMIT - 1));
    assign complete_o = (cnt_q == CNT_W'(LIMIT));

    if (PARITY_EN) begin : g_parity
        logic par_q;
        logic err_q;

        always_ff @(posedge clk) begin
            if (reset || clear_i) begin
                par_q <= 1'b0;
                err_q <= 1'b0;
            end else if (accept) begin
                if (data_phase) par_q <= par_q ^ d_i;
                else            err_q <= err_q | (par_q ^ d_i);
            end
        end

        assign parity_err_o = err_q;
    end else begin : g_no_parity
        assign parity_err_o = 1'b0;
    end

endmodule

// File: rtl/bnn_stream_loader.sv
// Serial input stage of the MNIST BNN: loads pixel and weight bit-streams into
// parallel vectors. Define LOADER_PARITY_EN for trailing per-stream parity bits.
module bnn_stream_loader #(
    parameter int PIX_BITS = bnn_pkg::PIX_BITS,
    parameter int W1_BITS  = bnn_pkg::W1_BITS,
    parameter int W2_BITS  = bnn_pkg::W2_BITS,
    parameter int W3_BITS  = bnn_pkg::W3_BITS
) (
    input  logic                clk,
    input  logic                reset,
    bnn_stream_loader_if.slave  bus
);
    import bnn_pkg::*;

    localparam int WT_LEN = W1_BITS + W2_BITS + W3_BITS;
`ifdef LOADER_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    loader_state_t     state_q;
    logic              busy_q;
    logic              done_q;
    logic              shift_en;
    logic              finishing;
    logic              pix_last, pix_complete, pix_err;
    logic              w_last, w_complete, w_err;
    logic [WT_LEN-1:0] w_data;

    // start wins over a coincident valid bit, which is discarded.
    assign shift_en = (state_q == LOAD) && bus.in_valid && !bus.start;

    bit_stream_shifter #(.LEN(PIX_BITS), .CNT_W(PIX_CNT_W), .PARITY_EN(PAR_EN)) u_pix (
        .clk(clk), .reset(reset), .clear_i(bus.start), .shift_i(shift_en),
        .d_i(bus.d_in_p), .data_o(bus.pixels), .last_o(pix_last),
        .complete_o(pix_complete), .parity_err_o(pix_err)
    );

    bit_stream_shifter #(.LEN(WT_LEN), .CNT_W(W_CNT_W), .PARITY_EN(PAR_EN)) u_wgt (
        .clk(clk), .reset(reset), .clear_i(bus.start), .shift_i(shift_en),
        .d_i(bus.d_in_w), .data_o(w_data), .last_o(w_last),
        .complete_o(w_complete), .parity_err_o(w_err)
    );

    assign finishing = (pix_last || pix_complete) && (w_last || w_complete);

    // NOTE: state and registered outputs all use non-blocking assignments so every
    // reader sees pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else if (bus.start) begin
            state_q <= LOAD;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
        end else if (state_q == LOAD && finishing) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
        end
    end

    assign bus.weights1   = w_data[W1_BITS-1:0];
    assign bus.weights2   = w_data[W1_BITS+W2_BITS-1:W1_BITS];
    assign bus.weights3   = w_data[WT_LEN-1:W1_BITS+W2_BITS];
    assign bus.busy       = busy_q;
    assign bus.load_done  = done_q;
    assign bus.parity_err = pix_err | w_err;

endmodule

// File: tb/tb_bnn_stream_loader.sv
// Self-checking bench for bnn_stream_loader: queue-based stream model compared
// every cycle, plus literal checks on reset, patterns, timing and restarts.
module tb_bnn_stream_loader;
    import bnn_pkg::*;

`ifdef LOADER_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif
    localparam int PLIM = PIX_BITS + (PAR ? 1 : 0);
    localparam int WLIM = WT + (PAR ? 1 : 0);

    logic clk = 1'b0;
    logic reset;
    bit   cmp_en = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    bnn_stream_loader_if bus ();

    bnn_stream_loader dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- reference model ----------------
    int m_state;  // 0 idle, 1 load, 2 done
    bit m_busy, m_done, m_perr, m_ppar, m_wpar;
    int m_pc, m_wc;
    bit pq[$];
    bit wq[$];

    always @(posedge clk) begin : model
        if (reset) begin
            m_state = 0; m_busy = 0; m_done = 0; m_perr = 0;
            m_pc = 0; m_wc = 0; m_ppar = 0; m_wpar = 0;
            pq.delete();
            wq.delete();
            for (int i = 0; i < PIX_BITS; i++) pq.push_back(1'b0);
            for (int i = 0; i < WT; i++) wq.push_back(1'b0);
        end else if (bus.start) begin
            m_state = 1; m_busy = 1; m_done = 0; m_perr = 0;
            m_pc = 0; m_wc = 0; m_ppar = 0; m_wpar = 0;
        end else if (m_state == 1 && bus.in_valid) begin
            if (m_pc < PIX_BITS) begin
                pq.push_back(bus.d_in_p);
                void'(pq.pop_front());
                m_ppar ^= bus.d_in_p;
                m_pc++;
            end else if (m_pc < PLIM) begin
                if (bus.d_in_p != m_ppar) m_perr = 1;
                m_pc++;
            end
            if (m_wc < WT) begin
                wq.push_back(bus.d_in_w);
                void'(wq.pop_front());
                m_wpar ^= bus.d_in_w;
                m_wc++;
            end else if (m_wc < WLIM) begin
                if (bus.d_in_w != m_wpar) m_perr = 1;
                m_wc++;
            end
            if (m_pc == PLIM && m_wc == WLIM) begin
                m_state = 2; m_busy = 0; m_done = 1;
            end
        end
    end

    // ---------------- check helpers ----------------
    task automatic check_bit(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %b required %b", name, act, exp);
        end
    endtask

    task automatic check_vec(input string name, input logic [WT-1:0] act, input logic [WT-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            int first = -1;
            n_fail++;
            for (int i = WT - 1; i >= 0; i--) if (act[i] !== exp[i]) first = i;
            $display("FAIL %s: first differing bit %0d actual %b required %b",
                     name, first, act[first], exp[first]);
        end
    endtask

    function automatic logic [WT-1:0] act_pix();
        logic [WT-1:0] v = '0;
        v[PIX_BITS-1:0] = bus.pixels;
        return v;
    endfunction

    function automatic logic [WT-1:0] act_wgt();
        return {bus.weights3, bus.weights2, bus.weights1};
    endfunction

    always @(negedge clk) begin : compare
        logic [WT-1:0] ep, ew;
        if (cmp_en) begin
            ep = '0;
            ew = '0;
            for (int i = 0; i < PIX_BITS; i++) ep[i] = pq[i];
            for (int i = 0; i < WT; i++) ew[i] = wq[i];
            check_bit("model_busy", bus.busy, m_busy);
            check_bit("model_load_done", bus.load_done, m_done);
            check_bit("model_parity_err", bus.parity_err, m_perr);
            check_vec("model_pixels", act_pix(), ep);
            check_vec("model_weights", act_wgt(), ew);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input logic s, input logic v, input logic p, input logic w);
        bus.start    = s;
        bus.in_valid = v;
        bus.d_in_p   = p;
        bus.d_in_w   = w;
        @(negedge clk);
    endtask

    function automatic bit pix_data(int mode, int k);
        return (mode == 1) ? 1'b1 : ((k % 2) == 0);
    endfunction

    function automatic bit w_data(int mode, int k);
        return (mode == 1) ? 1'b1 : (k[0] ^ k[3]);
    endfunction

    function automatic bit pix_bit(int mode, int k, bit flip);
        bit par = 0;
        if (k < PIX_BITS) return pix_data(mode, k);
        if (k == PIX_BITS) begin
            for (int i = 0; i < PIX_BITS; i++) par ^= pix_data(mode, i);
            return par ^ flip;
        end
        return 1'($urandom);
    endfunction

    function automatic bit w_bit(int mode, int k);
        bit par = 0;
        if (k < WT) return w_data(mode, k);
        for (int i = 0; i < WT; i++) par ^= w_data(mode, i);
        return par;
    endfunction

    task automatic load_stream(input int mode, input bit gap, input bit flip, input int n_bits);
        for (int k = 0; k < n_bits; k++) begin
            if (gap)
                for (int j = 0; j < 8 && $urandom_range(1, 0) == 0; j++)
                    tick(1'b0, 1'b0, 1'($urandom), 1'($urandom));
            if (k == WLIM - 1) check_bit("done_before_last_bit", bus.load_done, 1'b0);
            tick(1'b0, 1'b1, pix_bit(mode, k, flip), w_bit(mode, k));
            if (k == WLIM - 1) begin
                check_bit("done_after_last_bit", bus.load_done, 1'b1);
                check_bit("busy_after_last_bit", bus.busy, 1'b0);
            end
        end
    endtask

    logic [WT-1:0] pat_pix, ones_pix, ones_w;

    initial begin
        pat_pix  = '0;
        pat_pix[PIX_BITS-1:0] = {(PIX_BITS / 2){2'b01}};
        ones_pix = '0;
        ones_pix[PIX_BITS-1:0] = '1;
        ones_w   = '1;

        reset = 1'b1;
        bus.start = 1'b0; bus.in_valid = 1'b0; bus.d_in_p = 1'b0; bus.d_in_w = 1'b0;
        @(negedge clk);
        cmp_en = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_bit("reset_busy", bus.busy, 1'b0);
        check_bit("reset_load_done", bus.load_done, 1'b0);
        check_bit("reset_parity_err", bus.parity_err, 1'b0);
        check_vec("reset_pixels", act_pix(), '0);
        check_vec("reset_weights", act_wgt(), '0);
        tick(1'b0, 1'b1, 1'b1, 1'b1);

        // Full load with continuous valid.
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        check_bit("busy_after_start", bus.busy, 1'b1);
        load_stream(0, 1'b0, 1'b0, WLIM);
        check_vec("full_pixels_5555", act_pix(), pat_pix);
        check_bit("full_weights1_0", bus.weights1[0], 1'b0);
        check_bit("full_weights2_0", bus.weights2[0], 1'b1);
        check_bit("full_weights3_1959", bus.weights3[W3_BITS-1], 1'b0);
        check_bit("full_parity_err", bus.parity_err, 1'b0);

        // Valid outside LOAD is ignored.
        repeat (4) tick(1'b0, 1'b1, 1'($urandom), 1'($urandom));
        check_vec("done_hold_pixels", act_pix(), pat_pix);
        check_bit("done_hold_load_done", bus.load_done, 1'b1);

        // Gapped valid, same data.
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        check_bit("load_done_drops_after_start", bus.load_done, 1'b0);
        load_stream(0, 1'b1, 1'b0, WLIM);
        check_vec("gapped_pixels_5555", act_pix(), pat_pix);
        check_bit("gapped_weights2_0", bus.weights2[0], 1'b1);

        // Restart mid-load (start with a coincident valid bit), then all-ones.
        tick(1'b1, 1'b1, 1'b0, 1'b0);
        load_stream(0, 1'b0, 1'b0, 1000);
        tick(1'b1, 1'b1, 1'b0, 1'b0);
        load_stream(1, 1'b0, 1'b0, WLIM);
        check_vec("restart_pixels_ones", act_pix(), ones_pix);
        check_vec("restart_weights_ones", act_wgt(), ones_w);

        // Reset in the middle of a load.
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        load_stream(0, 1'b1, 1'b0, 500);
        reset = 1'b1;
        tick(1'b0, 1'b1, 1'b1, 1'b1);
        reset = 1'b0;
        check_bit("midreset_busy", bus.busy, 1'b0);
        check_vec("midreset_pixels", act_pix(), '0);
        check_vec("midreset_weights", act_wgt(), '0);
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        load_stream(0, 1'b0, 1'b0, WLIM);
        check_vec("after_reset_pixels", act_pix(), pat_pix);

`ifdef LOADER_PARITY_EN
        // Flipped pixel parity bit.
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        load_stream(0, 1'b0, 1'b1, WLIM);
        check_bit("flip_parity_err", bus.parity_err, 1'b1);
        check_bit("flip_load_done", bus.load_done, 1'b1);
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        check_bit("parity_err_cleared", bus.parity_err, 1'b0);
        load_stream(0, 1'b0, 1'b0, WLIM);
        check_bit("good_parity_err", bus.parity_err, 1'b0);
`endif

        tick(1'b0, 1'b0, 1'b0, 1'b0);
        cmp_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bnn_stream_loader.md
# bnn_stream_loader

Serial input stage of the MNIST BNN. Captures the pixel bit-stream and the concatenated weight bit-stream from two input pins, one bit per qualified cycle each. Presents the assembled pixel vector and the three weight vectors in parallel to layer one, layer two and the final layer. Signals `load_done` to the top-level FSM when both streams are complete.

## Interface
- `PIX_BITS`, default 784: pixel stream length (28×28 binary image).
- `W1_BITS`, default 72: layer-one weight bits.
- `W2_BITS`, default 288: layer-two weight bits.
- `W3_BITS`, default 1960: final-layer weight bits.
- `clk`, in, 1: single clock, rising edge.
- `reset`, in, 1: synchronous, active-high reset.
- `start`, in, 1: single-cycle pulse that begins (or restarts) a load.
- `in_valid`, in, 1: both data pins carry a valid bit this cycle.
- `d_in_p`, in, 1: pixel stream bit.
- `d_in_w`, in, 1: weight stream bit.
- `pixels`, out, PIX_BITS: assembled image.
- `weights1`, out, W1_BITS: layer-one weights.
- `weights2`, out, W2_BITS: layer-two weights.
- `weights3`, out, W3_BITS: final-layer weights.
- `busy`, out, 1: high while in LOAD.
- `load_done`, out, 1: both streams complete; level signal.
- `parity_err`, out, 1: stream parity mismatch (see Configuration).

## Operation
- Three states: IDLE, LOAD, DONE.
- IDLE → LOAD on `start`. In LOAD, `start` restarts the load: counters clear, state stays LOAD.
- DONE → LOAD on `start`. Otherwise DONE holds.
- Entering or restarting LOAD clears `pix_cnt` (10 b), `w_cnt` (12 b) and `parity_err`. Data registers are not cleared; they are overwritten by shifting.
- In LOAD, on a cycle with `in_valid` = 1:
  - The pixel shift register shifts right with `d_in_p` entering at MSB, if `pix_cnt` < PIX_BITS. Then `pix_cnt` increments.
  - The weight shift register {weights3, weights2, weights1} (WT = W1+W2+W3 = 2320 bits) shifts right with `d_in_w` entering at MSB, if `w_cnt` < WT. Then `w_cnt` increments.
  - Result: stream bit k lands at index k. The first pixel bit is `pixels[0]`. The first weight bit is `weights1[0]`. Weight bit 72 is `weights2[0]`. Weight bit 360 is `weights3[0]`.
- Streams finish independently. Once a counter saturates at its limit, further bits on that pin are ignored while the other stream continues.
- `in_valid` = 1 outside LOAD is ignored. No register changes.
- LOAD → DONE when both streams (and parity bits, if enabled) are complete.
- Counters never wrap; saturation is by comparison, not modulo.

## Timing
- Reset values: state IDLE, `busy` = 0, `load_done` = 0, `parity_err` = 0, `pixels` and all `weights*` = 0, counters 0.
- `start` at edge N: `busy` = 1 from N+1. First bit is accepted at the earliest at edge N+1.
- Last bit accepted at edge M: `load_done` = 1 and `busy` = 0 from M+1. Output vectors are final at M+1.
- Minimum load (disabled parity, `in_valid` held high): 2320 accepted cycles. Pixels finish after 784.
- `load_done` stays high in DONE until `start` or `reset`, then drops the cycle after.
- `start` and `in_valid` in the same cycle: `start` wins and that bit is discarded.
- `reset` mid-load: next cycle IDLE, outputs zeroed, the partial load is lost.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- Macro `LOADER_PARITY_EN`.
- Defined:
  - Each stream carries one extra trailing bit, accepted after its last data bit. That bit equals the XOR of all its data bits (even parity).
  - The pixel stream limit becomes PIX_BITS+1 and the weight stream limit becomes WT+1. Parity bits are not stored in the vectors.
  - A mismatch on either stream sets `parity_err`, sticky until the next `start` or `reset`. It is visible at the same edge as `load_done`.
  - `load_done` asserts regardless of parity outcome.
- Undefined: no trailing bits, no parity logic; `parity_err` is tied 0.

## Structure
- Shared package `bnn_pkg`: PIX_BITS, W1_BITS, W2_BITS, W3_BITS, WT, the counter widths, and enum `loader_state_t` {IDLE, LOAD, DONE}. These are shared with the FSM and the layers.
- One sub-module, `bit_stream_shifter`, parameterised by LEN and an optional parity enable. It holds the shift register, saturating counter, complete flag and running parity. It is instantiated twice: pixel (LEN=PIX_BITS) and weight (LEN=WT).

## Test plan
- **Reset:** `reset` held 2 cycles, then released → all outputs 0, `busy` = 0, `load_done` = 0.
- **Full load:** `start`, then 2320 valid cycles. Pixel bits alternate 1,0 (784 bits); weight bit k = k[0]^k[3]. Expect:
  - `pixels` = 0x…5555 pattern.
  - `weights1[0]` = first weight bit and `weights3[1959]` = last weight bit.
  - `load_done` = 1 exactly one cycle after the 2320th bit.
- **Gapped valid:** random 50 % `in_valid` gaps with the same data → identical final vectors. `load_done` timing tracks the last accepted bit.
- **Restart:** `start` again after 1000 bits, then a full new load of all-ones → all vectors all-ones, no residue from the first load.
- **Mid-load reset:** `reset` at bit 500 → next cycle IDLE and zero vectors. A subsequent full load completes normally.
- **Parity, `LOADER_PARITY_EN`:**
  - Correct trailing bits → `parity_err` = 0, `load_done` after 2321 bits.
  - Flipped pixel parity bit → `parity_err` = 1 with `load_done`. It clears on the next `start`.
